sc_shiftadd_sequencer: RTL

SC_SHIFTADD_SEQUENCER -- requirements
Module: sc_shiftadd_sequencer

---
 rtl/sc_datapath_pkg.sv | 85 ++++++++
 rtl/sc_uop_sequencer.sv | 34 +++
 rtl/sc_shiftadd_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sc_datapath_pkg.sv
// Shared encodings for the shift-and-add sequencer: FSM states, micro-op kinds,
// register-select / ALU / shifter codes and the idle control word.
package sc_datapath_pkg;

   localparam int unsigned DEC_W = 3;
   localparam int unsigned MUX_W = 3;
   localparam int unsigned ALU_W = 4;
   localparam int unsigned SHF_W = 2;
   localparam int unsigned ST_W  = 5;

   typedef enum logic [ST_W-1:0] {
      S_IDLE   = 5'd0,
      S_MOV2_0 = 5'd1,
      S_MOV2_1 = 5'd2,
      S_MOV2_2 = 5'd3,
      S_MOV3_0 = 5'd4,
      S_MOV3_1 = 5'd5,
      S_MOV3_2 = 5'd6,
      S_TEST   = 5'd7,
      S_ADD_0  = 5'd8,
      S_ADD_1  = 5'd9,
      S_ADD_2  = 5'd10,
      S_SHL_0  = 5'd11,
      S_SHL_1  = 5'd12,
      S_SHL_2  = 5'd13,
      S_SHL_3  = 5'd14,
      S_SHR_0  = 5'd15,
      S_SHR_1  = 5'd16,
      S_SHR_2  = 5'd17,
      S_SHR_3  = 5'd18,
      S_DONE   = 5'd19
   } state_e;

   typedef enum logic [2:0] {
      UOP_NONE = 3'd0,
      UOP_MOV  = 3'd1,
      UOP_ADD  = 3'd2,
      UOP_SHL  = 3'd3,
      UOP_SHR  = 3'd4
   } uop_e;

   // Bus read sources
   localparam logic [MUX_W-1:0] SEL_GEN0 = 3'b000;
   localparam logic [MUX_W-1:0] SEL_GEN1 = 3'b001;
   localparam logic [MUX_W-1:0] SEL_GEN2 = 3'b010;
   localparam logic [MUX_W-1:0] SEL_GEN3 = 3'b011;
   localparam logic [MUX_W-1:0] SEL_FIX0 = 3'b100;
   localparam logic [MUX_W-1:0] SEL_FIX1 = 3'b101;
   localparam logic [MUX_W-1:0] SEL_NONE = 3'b111;

   // Write targets
   localparam logic [DEC_W-1:0] DEC_GEN1 = 3'b001;
   localparam logic [DEC_W-1:0] DEC_GEN2 = 3'b010;
   localparam logic [DEC_W-1:0] DEC_GEN3 = 3'b011;
   localparam logic [DEC_W-1:0] DEC_NONE = 3'b111;

   // ALU operations
   localparam logic [ALU_W-1:0] ALU_PASS_A = 4'b0000;
   localparam logic [ALU_W-1:0] ALU_ADD    = 4'b1000;
   localparam logic [ALU_W-1:0] ALU_IDLE   = 4'b1111;

   // Shifter operations
   localparam logic [SHF_W-1:0] SHF_LEFT  = 2'b01;
   localparam logic [SHF_W-1:0] SHF_RIGHT = 2'b10;
   localparam logic [SHF_W-1:0] SHF_HOLD  = 2'b11;

   typedef struct packed {
      logic [DEC_W-1:0] dec;
      logic [MUX_W-1:0] mux_a;
      logic [MUX_W-1:0] mux_b;
      logic [ALU_W-1:0] alu;
      logic             load_n;
      logic [SHF_W-1:0] shift;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{
      dec:    DEC_NONE,
      mux_a:  SEL_NONE,
      mux_b:  SEL_NONE,
      alu:    ALU_IDLE,
      load_n: 1'b1,
      shift:  SHF_HOLD
   };

endpackage

// File: rtl/sc_uop_sequencer.sv
// Phase-indexed load/shift/write fields common to the MOV, ADD, SHL and SHR micro-ops.
// MOV/ADD: load in phase 1, write in phase 2. SHL/SHR: load 1, shift 2, write 3.
module sc_uop_sequencer
   import sc_datapath_pkg::*;
(
   input  uop_e             uop_i,
   input  logic [1:0]       phase_i,
   output logic             load_n_c,
   output logic [SHF_W-1:0] shift_c,
   output logic             write_c
);

   // Decode micro-op kind and phase into shifter/write strobes
   always_comb begin
      load_n_c = 1'b1;
      shift_c  = SHF_HOLD;
      write_c  = 1'b0;
      case (uop_i)
         UOP_MOV, UOP_ADD: begin
            load_n_c = (phase_i != 2'd1);
            write_c  = (phase_i == 2'd2);
         end
         UOP_SHL, UOP_SHR: begin
            load_n_c = (phase_i != 2'd1);
            write_c  = (phase_i == 2'd3);
            if (phase_i == 2'd2) begin
               shift_c = (uop_i == UOP_SHL) ? SHF_LEFT : SHF_RIGHT;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sc_shiftadd_sequencer.sv
// Shift-and-add multiply sequencer: RegGEN3 = RegGEN1 x RegFIX1 (low bits).
// Control outputs are registered from the next state so they line up with the
// current state. Optional macro SC_SHIFTADD_EARLYEXIT_EN ends the loop as soon
// as the multiplier register (RegGEN2) reads zero in TEST.
module sc_shiftadd_sequencer #(
   parameter int unsigned DATAWIDTH_BUS                 = 8,
   parameter int unsigned DATAWIDTH_DECODER_SELECTION   = 3,
   parameter int unsigned DATAWIDTH_MUX_SELECTION       = 3,
   parameter int unsigned DATAWIDTH_ALU_SELECTION       = 4,
   parameter int unsigned DATAWIDTH_REGSHIFTER_SELECTION = 2
) (
   input  logic                                      SC_SHIFTADD_SEQUENCER_CLOCK_50,
   input  logic                                      SC_SHIFTADD_SEQUENCER_Reset_InLow,
   input  logic                                      SC_SHIFTADD_SEQUENCER_Start_InHigh,
   input  logic                                      SC_SHIFTADD_SEQUENCER_Lsb_In,
   input  logic                                      SC_SHIFTADD_SEQUENCER_Zero_InLow,
   input  logic                                      SC_SHIFTADD_SEQUENCER_Carry_InLow,
   output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_SHIFTADD_SEQUENCER_DecoderSelectionWrite_Out,
   output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_SHIFTADD_SEQUENCER_MUXSelectionBUSA_Out,
   output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_SHIFTADD_SEQUENCER_MUXSelectionBUSB_Out,
   output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_SHIFTADD_SEQUENCER_ALUSelection_Out,
   output logic                                      SC_SHIFTADD_SEQUENCER_RegSHIFTERLoad_OutLow,
   output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_SHIFTADD_SEQUENCER_RegSHIFTERShiftSelection_OutLow,
   output logic                                      SC_SHIFTADD_SEQUENCER_Busy_Out,
   output logic                                      SC_SHIFTADD_SEQUENCER_Done_Out,
   output logic                                      SC_SHIFTADD_SEQUENCER_Overflow_Out
);
   import sc_datapath_pkg::*;

   localparam int unsigned   CNT_W   = $clog2(DATAWIDTH_BUS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATAWIDTH_BUS);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;

   uop_e             uop_c;
   logic [1:0]       phase_c;
   logic [MUX_W-1:0] mux_a_c, mux_b_c;
   logic [ALU_W-1:0] alu_c;
   logic [DEC_W-1:0] target_c;
   logic             load_n_c;
   logic [SHF_W-1:0] shift_c;
   logic             write_c;
   logic             early_exit_c;

`ifdef SC_SHIFTADD_EARLYEXIT_EN
   assign early_exit_c = ~SC_SHIFTADD_SEQUENCER_Zero_InLow;
`else
   logic unused_zero;
   assign unused_zero  = SC_SHIFTADD_SEQUENCER_Zero_InLow;
   assign early_exit_c = 1'b0;
`endif

   // Next state, iteration counter and sticky overflow
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE:   if (SC_SHIFTADD_SEQUENCER_Start_InHigh) state_d = S_MOV2_0;
         S_MOV2_0: state_d = S_MOV2_1;
         S_MOV2_1: state_d = S_MOV2_2;
         S_MOV2_2: state_d = S_MOV3_0;
         S_MOV3_0: state_d = S_MOV3_1;
         S_MOV3_1: state_d = S_MOV3_2;
         S_MOV3_2: state_d = S_TEST;
         S_TEST: begin
            if (early_exit_c)                     state_d = S_DONE;
            else if (cnt_q == CNT_MAX)            state_d = S_DONE;
            else if (SC_SHIFTADD_SEQUENCER_Lsb_In) state_d = S_ADD_0;
            else                                  state_d = S_SHL_0;
         end
         S_ADD_0:  state_d = S_ADD_1;
         S_ADD_1:  state_d = S_ADD_2;
         S_ADD_2:  state_d = S_SHL_0;
         S_SHL_0:  state_d = S_SHL_1;
         S_SHL_1:  state_d = S_SHL_2;
         S_SHL_2:  state_d = S_SHL_3;
         S_SHL_3:  state_d = S_SHR_0;
         S_SHR_0:  state_d = S_SHR_1;
         S_SHR_1:  state_d = S_SHR_2;
         S_SHR_2:  state_d = S_SHR_3;
         S_SHR_3:  state_d = S_TEST;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      if (state_d == S_MOV2_0) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else begin
         if ((state_q == S_SHR_3) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
         if ((state_q == S_ADD_1) && !SC_SHIFTADD_SEQUENCER_Carry_InLow) ovf_d = 1'b1;
      end
   end

   // Operand selects, ALU op and micro-op phase for the upcoming state
   always_comb begin
      uop_c    = UOP_NONE;
      phase_c  = 2'd0;
      mux_a_c  = SEL_NONE;
      mux_b_c  = SEL_NONE;
      alu_c    = ALU_IDLE;
      target_c = DEC_NONE;
      case (state_d)
         S_MOV2_0, S_MOV2_1, S_MOV2_2: begin
            uop_c    = UOP_MOV;
            phase_c  = 2'(ST_W'(state_d) - ST_W'(S_MOV2_0));
            mux_a_c  = SEL_FIX1;
            alu_c    = ALU_PASS_A;
            target_c = DEC_GEN2;
         end
         S_MOV3_0, S_MOV3_1, S_MOV3_2: begin
            uop_c    = UOP_MOV;
            phase_c  = 2'(ST_W'(state_d) - ST_W'(S_MOV3_0));
            mux_a_c  = SEL_FIX0;
            alu_c    = ALU_PASS_A;
            target_c = DEC_GEN3;
         end
         S_TEST: begin
            mux_a_c  = SEL_GEN2;
            alu_c    = ALU_PASS_A;
         end
         S_ADD_0, S_ADD_1, S_ADD_2: begin
            uop_c    = UOP_ADD;
            phase_c  = 2'(ST_W'(state_d) - ST_W'(S_ADD_0));
            mux_a_c  = SEL_GEN3;
            mux_b_c  = SEL_GEN1;
            alu_c    = ALU_ADD;
            target_c = DEC_GEN3;
         end
         S_SHL_0, S_SHL_1, S_SHL_2, S_SHL_3: begin
            uop_c    = UOP_SHL;
            phase_c  = 2'(ST_W'(state_d) - ST_W'(S_SHL_0));
            mux_a_c  = SEL_GEN1;
            alu_c    = ALU_PASS_A;
            target_c = DEC_GEN1;
         end
         S_SHR_0, S_SHR_1, S_SHR_2, S_SHR_3: begin
            uop_c    = UOP_SHR;
            phase_c  = 2'(ST_W'(state_d) - ST_W'(S_SHR_0));
            mux_a_c  = SEL_GEN2;
            alu_c    = ALU_PASS_A;
            target_c = DEC_GEN2;
         end
         default: ;
      endcase
   end

   sc_uop_sequencer u_uop (
      .uop_i    (uop_c),
      .phase_i  (phase_c),
      .load_n_c (load_n_c),
      .shift_c  (shift_c),
      .write_c  (write_c)
   );

   // Assemble the registered control word and status
   always_comb begin
      ctrl_d        = CTRL_IDLE;
      ctrl_d.dec    = write_c ? target_c : DEC_NONE;
      ctrl_d.mux_a  = mux_a_c;
      ctrl_d.mux_b  = mux_b_c;
      ctrl_d.alu    = alu_c;
      ctrl_d.load_n = load_n_c;
      ctrl_d.shift  = shift_c;
      busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d        = (state_d == S_DONE);
   end

   // State and output registers
   always_ff @(posedge SC_SHIFTADD_SEQUENCER_CLOCK_50 or negedge SC_SHIFTADD_SEQUENCER_Reset_InLow) begin
      if (!SC_SHIFTADD_SEQUENCER_Reset_InLow) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ctrl_q  <= CTRL_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign SC_SHIFTADD_SEQUENCER_DecoderSelectionWrite_Out       = DATAWIDTH_DECODER_SELECTION'(ctrl_q.dec);
   assign SC_SHIFTADD_SEQUENCER_MUXSelectionBUSA_Out            = DATAWIDTH_MUX_SELECTION'(ctrl_q.mux_a);
   assign SC_SHIFTADD_SEQUENCER_MUXSelectionBUSB_Out            = DATAWIDTH_MUX_SELECTION'(ctrl_q.mux_b);
   assign SC_SHIFTADD_SEQUENCER_ALUSelection_Out                = DATAWIDTH_ALU_SELECTION'(ctrl_q.alu);
   assign SC_SHIFTADD_SEQUENCER_RegSHIFTERLoad_OutLow           = ctrl_q.load_n;
   assign SC_SHIFTADD_SEQUENCER_RegSHIFTERShiftSelection_OutLow = DATAWIDTH_REGSHIFTER_SELECTION'(ctrl_q.shift);
   assign SC_SHIFTADD_SEQUENCER_Busy_Out                        = busy_q;
   assign SC_SHIFTADD_SEQUENCER_Done_Out                        = done_q;
   assign SC_SHIFTADD_SEQUENCER_Overflow_Out                    = ovf_q;

endmodule
